// File: rtl/mire_pkg.sv
// Shared definitions for the test-pattern ("mire") SDRAM writer.
//   state_e      : writer FSM states
//   PAT_*        : 2-bit pattern select codes
//   BAR_*        : the eight colour-bar colours, left to right
//   bar_color()  : maps a 3-bit bar index to its colour
package mire_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  localparam logic [1:0] PAT_GRID  = 2'd0;
  localparam logic [1:0] PAT_BARS  = 2'd1;
  localparam logic [1:0] PAT_GRAD  = 2'd2;
  localparam logic [1:0] PAT_BLACK = 2'd3;

  localparam logic [23:0] BAR_0 = 24'hFFFFFF;
  localparam logic [23:0] BAR_1 = 24'hFFFF00;
  localparam logic [23:0] BAR_2 = 24'h00FFFF;
  localparam logic [23:0] BAR_3 = 24'h00FF00;
  localparam logic [23:0] BAR_4 = 24'hFF00FF;
  localparam logic [23:0] BAR_5 = 24'hFF0000;
  localparam logic [23:0] BAR_6 = 24'h0000FF;
  localparam logic [23:0] BAR_7 = 24'h000000;

  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = BAR_0;
      3'd1:    c = BAR_1;
      3'd2:    c = BAR_2;
      3'd3:    c = BAR_3;
      3'd4:    c = BAR_4;
      3'd5:    c = BAR_5;
      3'd6:    c = BAR_6;
      default: c = BAR_7;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/wshb_if.sv
// Wishbone (pipelined-less, classic) bus bundle with its clock and reset.
//   clk, rst : bus clock and synchronous active-high reset
//   master   : drives adr, dat_ms, sel, we, stb, cyc, cti, bte; receives ack, dat_sm
//   slave    : the mirror view
interface wshb_if (
  input logic clk,
  input logic rst
);
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic [3:0]  sel;
  logic        we;
  logic        stb;
  logic        cyc;
  logic        ack;
  logic [2:0]  cti;
  logic [1:0]  bte;

  modport master (
    input  clk, rst, ack, dat_sm,
    output adr, dat_ms, sel, we, stb, cyc, cti, bte
  );

  modport slave (
    input  clk, rst, adr, dat_ms, sel, we, stb, cyc, cti, bte,
    output ack, dat_sm
  );
endinterface

// File: rtl/mire_pattern.sv
// Pixel-position tracker and registered RGB generator for the mire writer.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   advance_i      : step to the next pixel in raster order
//   restart_i      : jump to pixel (0,0) and latch pattern_sel_i
//   pattern_sel_i  : pattern code, only looked at on restart_i
//   rgb_o          : colour of the current pixel, registered
module mire_pattern
  import mire_pkg::*;
#(
  parameter int HDISP = 800,
  parameter int VDISP = 480
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        advance_i,
  input  logic        restart_i,
  input  logic [1:0]  pattern_sel_i,
  output logic [23:0] rgb_o
);

  // x keeps at least 10 bits so the gradient slice x[9:2] always exists;
  // y keeps at least 4 bits for the grid test on y[3:0].
  localparam int X_W   = ($clog2(HDISP) > 10) ? $clog2(HDISP) : 10;
  localparam int Y_W   = ($clog2(VDISP) > 4) ? $clog2(VDISP) : 4;
  localparam int BAR_W = HDISP / 8;
  localparam int SEG_W = ($clog2(BAR_W) > 1) ? $clog2(BAR_W) : 1;

  localparam logic [X_W-1:0]   X_LAST   = X_W'(HDISP - 1);
  localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(VDISP - 1);
  localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(BAR_W - 1);

  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic [2:0]       bar_q, bar_d;
  logic [1:0]       pat_q, pat_d;
  logic [23:0]      rgb_q, rgb_d;

  function automatic logic [23:0] pixel_rgb(input logic [1:0]     pat,
                                            input logic [X_W-1:0] x,
                                            input logic [Y_W-1:0] y,
                                            input logic [2:0]     bar);
    logic [23:0] c;
    case (pat)
      PAT_GRID: c = ((x[3:0] == 4'd0) || (y[3:0] == 4'd0)) ? 24'hFFFFFF : 24'h000000;
      PAT_BARS: c = bar_color(bar);
      PAT_GRAD: c = {x[9:2], x[9:2], x[9:2]};
      default:  c = 24'h000000;
    endcase
    return c;
  endfunction

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    seg_d = seg_q;
    bar_d = bar_q;
    pat_d = pat_q;
    if (restart_i) begin
      x_d   = '0;
      y_d   = '0;
      seg_d = '0;
      bar_d = '0;
      pat_d = pattern_sel_i;
    end else if (advance_i) begin
      if (x_q == X_LAST) begin
        x_d   = '0;
        seg_d = '0;
        bar_d = '0;
        y_d   = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
        // Bar index steps every BAR_W pixels; it saturates at 7 so a line
        // width that is not a multiple of 8 just widens the last bar.
        if (seg_q == SEG_LAST) begin
          seg_d = '0;
          if (bar_q != 3'd7) bar_d = bar_q + 1'b1;
        end else begin
          seg_d = seg_q + 1'b1;
        end
      end
    end
    // Colour is computed from the next position so it lands in the register
    // together with the address it belongs to.
    rgb_d = pixel_rgb(pat_d, x_d, y_d, bar_d);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q   <= '0;
      y_q   <= '0;
      seg_q <= '0;
      bar_q <= '0;
      pat_q <= PAT_GRID;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      seg_q <= seg_d;
      bar_q <= bar_d;
      pat_q <= pat_d;
    end
  end

  always_ff @(posedge clk_i) begin
    rgb_q <= rgb_d;
  end

  assign rgb_o = rgb_q;

endmodule

// File: rtl/mire_writer.sv
// Test-pattern writer: streams HDISP*VDISP 32-bit pixels into memory over a
// Wishbone master, raster order, pixel i at byte address 4*i, forever.
// The bus is released for one cycle after every BURST_LEN acknowledged writes.
//   wshb_ifm    : Wishbone master (carries clk and rst)
//   pattern_sel : pattern code, taken at each frame start
//   frame_done  : one-cycle pulse following the ack of a frame's last pixel
//   frame_cnt   : completed frames, wrapping
module mire_writer
  import mire_pkg::*;
#(
  parameter int HDISP     = 800,
  parameter int VDISP     = 480,
  parameter int BURST_LEN = 64
) (
  wshb_if.master      wshb_ifm,
  input  logic [1:0]  pattern_sel,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam int              TOTAL      = HDISP * VDISP;
  localparam logic [29:0]     PIX_LAST   = 30'(TOTAL - 1);
  localparam int              BW         = $clog2(BURST_LEN + 1);
  localparam logic [BW-1:0]   BURST_LAST = BW'(BURST_LEN - 1);

  state_e         state_q, state_d;
  logic [29:0]    pix_q, pix_d;
  logic [BW-1:0]  burst_q, burst_d;
  logic [15:0]    fcnt_q, fcnt_d;
  logic           fdone_q, fdone_d;
  logic           bus_act;
  logic           advance;
  logic           restart;
  logic [23:0]    rgb;
  logic           unused_dat_sm;

  assign unused_dat_sm = ^wshb_ifm.dat_sm;

  mire_pattern #(
    .HDISP(HDISP),
    .VDISP(VDISP)
  ) u_pattern (
    .clk_i        (wshb_ifm.clk),
    .rst_i        (wshb_ifm.rst),
    .advance_i    (advance),
    .restart_i    (restart),
    .pattern_sel_i(pattern_sel),
    .rgb_o        (rgb)
  );

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    burst_d = burst_q;
    fcnt_d  = fcnt_q;
    fdone_d = 1'b0;
    bus_act = 1'b0;
    advance = 1'b0;
    restart = 1'b0;
    case (state_q)
      ST_IDLE: begin
        restart = 1'b1;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        bus_act = 1'b1;
        if (wshb_ifm.ack) begin
          burst_d = burst_q + 1'b1;
          if (pix_q == PIX_LAST) begin
            pix_d   = '0;
            restart = 1'b1;
            fdone_d = 1'b1;
            fcnt_d  = fcnt_q + 16'd1;
          end else begin
            pix_d   = pix_q + 1'b1;
            advance = 1'b1;
          end
          // Frame wrap above and the tenure end here are independent.
          if (burst_q == BURST_LAST) state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        burst_d = '0;
        state_d = ST_WRITE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wshb_ifm.clk) begin
    if (wshb_ifm.rst) begin
      state_q <= ST_IDLE;
      pix_q   <= '0;
      burst_q <= '0;
      fcnt_q  <= '0;
      fdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      burst_q <= burst_d;
      fcnt_q  <= fcnt_d;
      fdone_q <= fdone_d;
    end
  end

  // cyc/stb come straight from the state register, so reset drops them on
  // the same edge it is sampled.
  assign wshb_ifm.cyc    = bus_act;
  assign wshb_ifm.stb    = bus_act;
  assign wshb_ifm.adr    = {pix_q, 2'b00};
  assign wshb_ifm.dat_ms = {8'h00, rgb};
  assign wshb_ifm.we     = 1'b1;
  assign wshb_ifm.sel    = 4'b1111;
  assign wshb_ifm.cti    = 3'b000;
  assign wshb_ifm.bte    = 2'b00;

  assign frame_done = fdone_q;
  assign frame_cnt  = fcnt_q;

endmodule
